// File: rtl/seq_div_pkg.sv
// Shared types and sizing helpers for the sequential unsigned divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Iteration counter must index 2*W quotient bits (values 2*W-1 down to 0).
    function automatic int cnt_width(input int w);
        return (2 * w > 1) ? $clog2(2 * w) : 1;
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift in next dividend bit, trial-subtract divisor.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module seq_div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] rem_in,
    input  logic         q_msb,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    // Partial remainder widened by one bit so the trial compare cannot overflow.
    logic [W:0] s;

    assign s     = {rem_in, q_msb};
    assign q_bit = (s >= {1'b0, divisor});
    // When the subtract succeeds the true difference is below divisor, so it fits
    // in W bits and the low-W-bit subtraction gives the exact result.
    assign rem_out = q_bit ? (s[W-1:0] - divisor) : s[W-1:0];

endmodule

// File: rtl/seq_unsigned_divider.sv
// Restoring unsigned divider, 2W/W -> 2W quotient + W remainder, one quotient bit per clock.
// Latency: 2*W clocks after accept; divide-by-zero (and early exit, SEQ_DIV_EARLY_EXIT_EN) 1 clock.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no same-cycle re-accept.
module seq_unsigned_divider
    import seq_div_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int CW = cnt_width(W);

    div_state_e     state;
    div_state_e     state_nxt;
    logic [CW-1:0]  cnt;
    // Partial remainder; the extra bit of the W+1-bit step value is always zero
    // after a step, so only W bits are stored.
    logic [W-1:0]   rem;
    logic [W-1:0]   dsr;
    logic [2*W-1:0] q;
    logic [2*W-1:0] quot_r;
    logic [W-1:0]   rem_r;
    logic           dbz_r;
    logic           accept;
    logic           early;
    logic           div_zero;
    logic [W-1:0]   step_rem;
    logic           step_bit;

    // Held low while reset is asserted so nothing is offered during reset.
    assign in_ready    = (state == IDLE) && rst_n;
    assign out_valid   = (state == DONE);
    assign accept      = in_valid && in_ready;
    assign div_zero    = (divisor == '0);
    assign quotient    = quot_r;
    assign remainder   = rem_r;
    assign div_by_zero = dbz_r;

`ifdef SEQ_DIV_EARLY_EXIT_EN
    // Dividend smaller than divisor: quotient is 0 and remainder is the dividend.
    assign early = (dividend < {{W{1'b0}}, divisor});
`else
    assign early = 1'b0;
`endif

    seq_div_step #(.W(W)) u_step (
        .rem_in  (rem),
        .q_msb   (q[2*W-1]),
        .divisor (dsr),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: zero divisor and early exit skip RUN entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (div_zero || early) ? DONE : RUN;
            RUN:  if (cnt == '0) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture on accept, one shift/subtract per RUN clock,
    // result registers loaded only when entering DONE so they stay stable afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            rem    <= '0;
            dsr    <= '0;
            q      <= '0;
            quot_r <= '0;
            rem_r  <= '0;
            dbz_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dsr <= divisor;
                        if (div_zero) begin
                            quot_r <= '1;
                            rem_r  <= dividend[W-1:0];
                            dbz_r  <= 1'b1;
                        end else begin
                            dbz_r <= 1'b0;
                            if (early) begin
                                quot_r <= '0;
                                rem_r  <= dividend[W-1:0];
                            end else begin
                                cnt <= CW'(2 * W - 1);
                                rem <= '0;
                                q   <= dividend;
                            end
                        end
                    end
                end
                RUN: begin
                    rem <= step_rem;
                    q   <= {q[2*W-2:0], step_bit};
                    if (cnt == '0) begin
                        quot_r <= {q[2*W-2:0], step_bit};
                        rem_r  <= step_rem;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
